// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default sizes,
// the boundary operand constants and the controller state encoding.
package div_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // Operand pair that cannot be represented as a quotient (INT_MIN / -1)
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and record the
// resulting quotient bit in the vacated LSB of the dividend register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_dvd
);

  // Shifted remainder is one bit wider so the compare never loses the MSB
  logic [WIDTH:0] shifted;

  // Trial subtraction and quotient-bit insertion
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    next_dvd = {dvd[WIDTH-2:0], 1'b0};
    next_rem = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor}) begin
      next_rem    = shifted[WIDTH-1:0] - divisor;
      next_dvd[0] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed integer divider (restoring, one quotient bit per cycle).
// Operands are converted to magnitudes at start, divided over WIDTH cycles,
// sign-corrected in FIX and published with a one-cycle ready pulse in DONE.
// Optional: define SEQ_DIVIDER_REMAINDER_EN to produce the signed remainder;
// without it data_remainder is constantly zero.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH,
  parameter int CNT_W = div_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  // Width-generic versions of INT_MIN and -1 for the overflow test
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_VAL = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic             sign_q_reg;
  logic             exc_reg;
  logic [WIDTH-1:0] quo_reg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic             ovf;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  // Operand magnitudes and the two exceptional cases, evaluated at start
  always_comb begin
    abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    b_zero = (data_operandB == '0);
    ovf    = (data_operandA == MIN_VAL) && (data_operandB == ONES_VAL);
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_reg),
    .dvd     (dvd_reg),
    .divisor (dsr_reg),
    .next_rem(step_rem),
    .next_dvd(step_dvd)
  );

  // Controller and quotient datapath; a start strobe always wins, which
  // gives abort-and-restart in RUN/FIX and back-to-back issue from DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rem_reg        <= '0;
      dvd_reg        <= '0;
      dsr_reg        <= '0;
      sign_q_reg     <= 1'b0;
      exc_reg        <= 1'b0;
      quo_reg        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;

      case (state_reg)
        RUN: begin
          rem_reg <= step_rem;
          dvd_reg <= step_dvd;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          quo_reg   <= sign_q_reg ? -dvd_reg : dvd_reg;
          state_reg <= DONE;
        end
        DONE: begin
          data_result    <= quo_reg;
          data_exception <= exc_reg;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: ;
      endcase

      if (ctrl_DIV) begin
        dvd_reg    <= abs_a;
        dsr_reg    <= abs_b;
        rem_reg    <= '0;
        cnt_reg    <= '0;
        sign_q_reg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        exc_reg    <= b_zero | ovf;
        busy       <= 1'b1;
        if (b_zero) begin
          // Nothing to iterate: publish zero on the next edge
          quo_reg   <= '0;
          state_reg <= DONE;
        end else begin
          state_reg <= RUN;
        end
      end
    end
  end

`ifdef SEQ_DIVIDER_REMAINDER_EN
  logic             sign_r_reg;
  logic [WIDTH-1:0] rfix_reg;

  // Remainder takes the dividend's sign; divide-by-zero returns the dividend
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sign_r_reg     <= 1'b0;
      rfix_reg       <= '0;
      data_remainder <= '0;
    end else begin
      if (state_reg == FIX) begin
        rfix_reg <= sign_r_reg ? -rem_reg : rem_reg;
      end
      if (state_reg == DONE) begin
        data_remainder <= rfix_reg;
      end
      if (ctrl_DIV) begin
        sign_r_reg <= data_operandA[WIDTH-1];
        if (b_zero) begin
          rfix_reg <= data_operandA;
        end
      end
    end
  end
`else
  assign data_remainder = '0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes hand-computed results
// with the edge at which ready must appear; a negedge monitor pops and
// compares every ready pulse.
module tb_seq_divider;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        e;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   s;
  int   s1;

  // Signed cases without exceptions: A, B, quotient, remainder
  logic [31:0] tv_a [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd100,       32'd7, 32'hFFFF_FF9C};
  logic [31:0] tv_b [5] = '{32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFF9};
  logic [31:0] tv_q [5] = '{32'h8000_0000, 32'd1,         32'hFFFF_FFF2, 32'd0, 32'd14};
  logic [31:0] tv_r [5] = '{32'd0,         32'd0,         32'd2,         32'd7, 32'hFFFF_FFFE};

  seq_divider dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] exp_r(input logic [31:0] r);
`ifdef SEQ_DIVIDER_REMAINDER_EN
    return r;
`else
    return r & 32'h0;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (edge %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest scoreboard entry
  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy: got ready with result %h at edge %0d, required none", data_result, cyc);
      end else begin
        mon_e = sb.pop_front();
        $display("txn edge=%0d result=%h remainder=%h exception=%b", cyc, data_result, data_remainder, data_exception);
        check32("result", data_result, mon_e.q);
        check32("remainder", data_remainder, mon_e.r);
        check32("exception", {31'b0, data_exception}, {31'b0, mon_e.e});
        check32("ready_edge", 32'(cyc), 32'(mon_e.edge_n));
      end
    end
  end

  // Drive a start strobe; s is the edge that samples it
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                       input logic [31:0] q, input logic [31:0] r, input logic e,
                       input int lat, output int s_out);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    s_out         = cyc + 1;
    if (push) begin
      x.q = q; x.r = exp_r(r); x.e = e; x.edge_n = s_out + lat;
      sb.push_back(x);
    end
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check32("rst_result", data_result, 32'd0);
    check32("rst_remainder", data_remainder, 32'd0);
    check32("rst_exception", {31'b0, data_exception}, 32'd0);
    check32("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    check32("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 100 / 7 with busy window checks
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34, s);
    check32("busy_start", {31'b0, busy}, 32'd1);
    go_to(s + 33);
    check32("busy_last", {31'b0, busy}, 32'd1);
    go_to(s + 34);
    check32("busy_clear", {31'b0, busy}, 32'd0);
    drain();

    // Divide by zero: one-edge latency, remainder = dividend
    issue(32'd5, 32'd0, 1'b1, 32'd0, 32'd5, 1'b1, 1, s);
    check32("dz_busy", {31'b0, busy}, 32'd1);
    go_to(s + 1);
    check32("dz_busy_clear", {31'b0, busy}, 32'd0);
    drain();

    // INT_MIN / -1 overflow
    issue(div_pkg::INT_MIN, div_pkg::NEG_ONE, 1'b1, div_pkg::INT_MIN, 32'd0, 1'b1, 34, s);
    drain();

    for (int i = 0; i < 5; i++) begin
      issue(tv_a[i], tv_b[i], 1'b1, tv_q[i], tv_r[i], 1'b0, 34, s);
      drain();
    end

    // Abort at edge +5 with 9 / 3; only the restart completes
    issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 34, s);
    go_to(s + 4);
    issue(32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 34, s1);
    drain();

    // Start in the DONE cycle: both results must appear
    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34, s);
    go_to(s + 33);
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, s1);
    drain();

    // Asynchronous reset mid-operation
    issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 34, s);
    go_to(s + 10);
    #2 reset_n = 1'b0;
    #1;
    check32("arst_result", data_result, 32'd0);
    check32("arst_remainder", data_remainder, 32'd0);
    check32("arst_exception", {31'b0, data_exception}, 32'd0);
    check32("arst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check32("post_rst_busy", {31'b0, busy}, 32'd0);

    issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34, s);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle 32-bit signed integer divider for the CPU execute stage.
- Pairs with the single-cycle ALU bitwise and arithmetic units; this block is the inverse of the team's multiply path.
- Sits beside the ALU; the pipeline stalls on `busy` and captures the result on `data_resultRDY`.
- Restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock, the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- data_operandA  input  WIDTH  dividend, two's complement.
- data_operandB  input  WIDTH  divisor, two's complement.
- ctrl_DIV  input  1  start strobe, sampled each rising edge.
- data_result  output  WIDTH  quotient, registered.
- data_remainder  output  WIDTH  remainder, registered; see Optional Feature.
- data_exception  output  1  divide-by-zero or overflow flag, registered.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; data_result, data_remainder, data_exception, data_resultRDY, busy all 0; counter 0.
- States:
  - IDLE: wait for ctrl_DIV.
  - RUN: 32 iterations.
  - FIX: sign correction.
  - DONE: pulse ready.
- IDLE -> RUN on ctrl_DIV=1.
  - At that edge, latch |A|, |B|, sign_q = A[31]^B[31], sign_r = A[31].
  - Clear the partial remainder; counter = 0; busy=1.
- RUN, each cycle:
  - rem = {rem[30:0], dvd[31]}; dvd <<= 1.
  - If rem >= |B|: rem -= |B| and dvd[0] = 1.
  - Counter increments. After the 32nd iteration (counter==31), go to FIX.
- FIX:
  - q = sign_q ? -dvd : dvd.
  - r = sign_r ? -rem : rem.
  - Then go to DONE.
- DONE:
  - data_result, data_remainder, data_exception load.
  - data_resultRDY = 1 for exactly this cycle; busy drops to 0.
  - Next state IDLE.
- Latency: data_resultRDY is high in the cycle starting 34 edges after the edge that sampled ctrl_DIV.
- Outputs hold their values until the next DONE or reset.
- Divide-by-zero (B==0 at start):
  - Skip RUN/FIX; go straight to DONE.
  - data_resultRDY is high 1 edge after start.
  - data_result=0, data_remainder=A, data_exception=1.
- Overflow (A=0x80000000, B=0xFFFFFFFF):
  - Normal latency.
  - data_result=0x80000000, data_remainder=0, data_exception=1.
- All other cases: data_exception=0.
- ctrl_DIV=1 while busy (RUN/FIX): abort the current operation, relatch operands, restart RUN from counter 0. No data_resultRDY is produced for the aborted operation.
- ctrl_DIV=1 in the DONE cycle: the DONE outputs and RDY still occur; the new operation starts the same edge.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no RDY.
- Quotient truncates toward zero; remainder takes the dividend's sign.

Optional Feature:
- Macro: SEQ_DIVIDER_REMAINDER_EN.
- Defined: data_remainder carries the signed remainder as specified above.
- Undefined:
  - The remainder sign-fix logic and output register are removed.
  - data_remainder is tied to 0 at all times, including the divide-by-zero case.
  - Quotient, exception and latency are unchanged.

Decomposition:
- Shared package div_pkg:
  - State encoding: IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3.
  - WIDTH, CNT_W.
  - Constants INT_MIN=32'h80000000 and NEG_ONE=32'hFFFFFFFF.
- One natural sub-module: div_step.
  - Combinational single restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd.
  - Instantiated once inside the RUN datapath.

Test Plan:
- A=100, B=7, ctrl_DIV pulse -> busy high 34 cycles; RDY at edge +34; result=14, remainder=2, exception=0.
- A=-100 (0xFFFFFF9C), B=7 -> result=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2), exception=0.
- A=5, B=0 -> RDY at edge +1; result=0, remainder=5, exception=1; busy high for one cycle only.
- A=0x80000000, B=0xFFFFFFFF -> RDY at edge +34; result=0x80000000, remainder=0, exception=1.
- Start 100/7, then at edge +5 pulse ctrl_DIV with A=9, B=3 -> no RDY for the first operation; RDY 34 edges after the restart; result=3, remainder=0.
- Start 100/7, drive reset_n=0 asynchronously mid-cycle at edge +10 -> all outputs 0 immediately, no RDY afterwards; a fresh 100/7 after release gives result 14.
